// File: rtl/core_pkg.sv
// Shared core types and widths used by the memory arbiter and its ID queue.
package core_pkg;

  localparam int CoreXlen = 32;
  localparam int CoreIlen = 32;

  // Identifies which core port issued a memory request.
  typedef enum logic {
    SrcInst = 1'b0,
    SrcData = 1'b1
  } mem_src_e;

  // Arbiter grant state: free to choose, or holding a stalled grant.
  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Round-robin helper: the requester that did not win last time.
  function automatic mem_src_e other_src(input mem_src_e src);
    return (src == SrcInst) ? SrcData : SrcInst;
  endfunction

endpackage

// File: rtl/mem_arb_idq.sv
// Circular queue of request sources, one entry per outstanding read.
module mem_arb_idq
  import core_pkg::*;
#(
  parameter int DepthLog2 = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  mem_src_e push_src_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output mem_src_e head_o
);

  localparam int Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0] PtrOne = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DepthLog2:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2:0] rd_ptr_q, rd_ptr_d;
  mem_src_e           slots_q [Depth];
  logic               do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]) &&
                   (wr_ptr_q[DepthLog2-1:0] == rd_ptr_q[DepthLog2-1:0]);
  assign head_o  = slots_q[rd_ptr_q[DepthLog2-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Advance pointers on accepted push/pop.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; written only at the tail.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; an entry is only read after it has been written, and the empty pointers make stale contents unreachable.
    if (do_push) slots_q[wr_ptr_q[DepthLog2-1:0]] <= push_src_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one round-robin arbiter sharing one memory port between fetch and data,
// with in-order read response routing.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int Xlen      = CoreXlen,
  parameter int Ilen      = CoreIlen,
  parameter int MaskBits  = Xlen / 8,
  parameter int DepthLog2 = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inst_valid_i,
  output logic                inst_ready_o,
  input  logic [Xlen-1:0]     inst_addr_i,
  input  logic [Ilen-1:0]     inst_wdata_i,
  input  logic [MaskBits-1:0] inst_wmask_i,
  output logic [Ilen-1:0]     inst_rdata_o,
  output logic                inst_rvalid_o,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  logic [Xlen-1:0]     data_addr_i,
  input  logic [Xlen-1:0]     data_wdata_i,
  input  logic [MaskBits-1:0] data_wmask_i,
  output logic [Xlen-1:0]     data_rdata_o,
  output logic                data_rvalid_o,
  input  logic                mem_ready_i,
  output logic                mem_valid_o,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i,
  output logic                err_o
);

  arb_state_e state_q, state_d;
  mem_src_e   lock_src_q, lock_src_d;
  mem_src_e   last_q, last_d;
  logic       err_q, err_d;

  mem_src_e   grant;
  logic       gnt_valid, gnt_read, blocked, accept;
  logic       q_full, q_empty, push, pop;
  mem_src_e   q_head;

  // Choose the granted source: a held grant wins, otherwise round-robin on ties.
  always_comb begin
    grant = SrcInst;
    if (state_q == ArbLocked)            grant = lock_src_q;
    else if (inst_valid_i && data_valid_i) grant = other_src(last_q);
    else if (data_valid_i)               grant = SrcData;
  end

  // Mux the granted request onto the unified port.
  always_comb begin
    gnt_valid   = inst_valid_i;
    mem_addr_o  = inst_addr_i;
    mem_wdata_o = Xlen'(inst_wdata_i);
    mem_wmask_o = inst_wmask_i;
    if (grant == SrcData) begin
      gnt_valid   = data_valid_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
      mem_wmask_o = data_wmask_i;
    end
  end

  // A read is held off while every tracking slot is in use; writes never are.
  assign gnt_read     = (mem_wmask_o == '0);
  assign blocked      = gnt_read && q_full;
  assign mem_valid_o  = rst_ni && gnt_valid && !blocked;
  assign inst_ready_o = rst_ni && (grant == SrcInst) && mem_ready_i && !blocked;
  assign data_ready_o = rst_ni && (grant == SrcData) && mem_ready_i && !blocked;
  assign accept       = mem_valid_o && mem_ready_i;

  // Responses: rdata is passed straight through, only rvalid is steered.
  assign push          = accept && gnt_read;
  assign pop           = mem_rvalid_i && !q_empty;
  assign inst_rvalid_o = pop && (q_head == SrcInst);
  assign data_rvalid_o = pop && (q_head == SrcData);
  assign inst_rdata_o  = mem_rdata_i[Ilen-1:0];
  assign data_rdata_o  = mem_rdata_i;
  assign err_o         = err_q;

  mem_arb_idq #(.DepthLog2(DepthLog2)) u_idq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_src_i (grant),
    .pop_i      (pop),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .head_o     (q_head)
  );

  // Next-state: lock a stalled grant, release on acceptance, track last winner and orphan responses.
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    last_d     = last_q;
    err_d      = err_q || (mem_rvalid_i && q_empty);
    case (state_q)
      ArbIdle: begin
        if (mem_valid_o && !mem_ready_i) begin
          state_d    = ArbLocked;
          lock_src_d = grant;
        end
      end
      ArbLocked: begin
        if (accept) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
    if (accept) last_d = grant;
  end

  // Arbiter registers; reset makes data win the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      lock_src_q <= SrcInst;
      last_q     <= SrcInst;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

endmodule
